// File: rtl/frame_state_latch.sv
// Double-buffers the per-player state vectors so the VGA side only ever sees a
// new pair at a vsync boundary; also keeps frame/animation/staleness counters.
module frame_state_latch #(
    parameter int ANIM_DIV = 8,
    parameter int FRAME_W  = 16
) (
    input  logic               iVGA_CLK,
    input  logic               reset,
    input  logic               iVS,
    input  logic [127:0]       p1_in,
    input  logic [127:0]       p2_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [127:0]       p1VGA,
    output logic [127:0]       p2VGA,
    output logic               swap_pulse,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic [1:0]         anim_phase,
    output logic [7:0]         stale_cnt,
    output logic [1:0]         fsm_state
);

    localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             vs_q;
    logic             vs_fall;
    logic             capture;
    logic             commit;
    logic [127:0]     pend_p1, pend_p2;
    logic [DIV_W-1:0] anim_div;

    assign vs_fall   = vs_q & ~iVS;
    assign fsm_state = state_q;

    // Handshake: an offer transfers on any rising edge where in_valid and
    // in_ready are both high; in_ready depends only on state, never on in_valid.
    assign in_ready = (state_q == EMPTY);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        commit  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_valid) begin
                    capture = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (vs_fall) state_d = COMMIT;
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            vs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            vs_q    <= iVS;
        end
    end

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            pend_p1    <= '0;
            pend_p2    <= '0;
            p1VGA      <= '0;
            p2VGA      <= '0;
            swap_pulse <= 1'b0;
        end else begin
            swap_pulse <= commit;
            if (capture) begin
                pend_p1 <= p1_in;
                pend_p2 <= p2_in;
            end
            if (commit) begin
                p1VGA <= pend_p1;
                p2VGA <= pend_p2;
            end
        end
    end

    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            frame_cnt  <= '0;
            anim_div   <= '0;
            anim_phase <= 2'd0;
        end else if (vs_fall) begin
            frame_cnt <= frame_cnt + 1'b1;
            if (anim_div == DIV_LAST) begin
                anim_div   <= '0;
                anim_phase <= anim_phase + 2'd1;
            end else begin
                anim_div <= anim_div + 1'b1;
            end
        end
    end

    // Staleness counts frames the display went without a waiting update.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            stale_cnt <= 8'd0;
        end else if (commit) begin
            stale_cnt <= 8'd0;
        end else if (vs_fall && state_q != FULL && stale_cnt != 8'hFF) begin
            stale_cnt <= stale_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_frame_state_latch.sv
// Bench for frame_state_latch: directed scenarios plus a randomized run, all
// checked against an event-level model of when offers reach the display.
module tb_frame_state_latch;

    localparam int ANIM_DIV = 8;

    logic         iVGA_CLK = 1'b0;
    logic         reset;
    logic         iVS;
    logic [127:0] p1_in, p2_in;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] p1VGA, p2VGA;
    logic         swap_pulse;
    logic [15:0]  frame_cnt;
    logic [1:0]   anim_phase;
    logic [7:0]   stale_cnt;
    logic [1:0]   fsm_state;

    logic         w_in_ready, w_swap;
    logic [127:0] w_p1, w_p2;
    logic [3:0]   w_frame_cnt;
    logic [1:0]   w_anim, w_state;
    logic [7:0]   w_stale;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 iVGA_CLK = ~iVGA_CLK;

    frame_state_latch #(.ANIM_DIV(ANIM_DIV), .FRAME_W(16)) dut (
        .iVGA_CLK(iVGA_CLK), .reset(reset), .iVS(iVS),
        .p1_in(p1_in), .p2_in(p2_in), .in_valid(in_valid), .in_ready(in_ready),
        .p1VGA(p1VGA), .p2VGA(p2VGA), .swap_pulse(swap_pulse),
        .frame_cnt(frame_cnt), .anim_phase(anim_phase), .stale_cnt(stale_cnt),
        .fsm_state(fsm_state)
    );

    frame_state_latch #(.ANIM_DIV(ANIM_DIV), .FRAME_W(4)) dut4 (
        .iVGA_CLK(iVGA_CLK), .reset(reset), .iVS(iVS),
        .p1_in(p1_in), .p2_in(p2_in), .in_valid(in_valid), .in_ready(w_in_ready),
        .p1VGA(w_p1), .p2VGA(w_p2), .swap_pulse(w_swap),
        .frame_cnt(w_frame_cnt), .anim_phase(w_anim), .stale_cnt(w_stale),
        .fsm_state(w_state)
    );

    // Reference model: an accepted offer waits for the next vsync falling edge
    // and reaches the display on the edge after it.
    logic [127:0] m_p1, m_p2, m_pend1, m_pend2;
    bit           m_waiting, m_commit_due, m_swap, m_prev_vs;
    int           m_frames, m_stale;

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic bit m_ready();
        return !m_waiting && !m_commit_due;
    endfunction

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_pend1 = '0; m_pend2 = '0;
        m_waiting = 0; m_commit_due = 0; m_swap = 0; m_prev_vs = 1;
        m_frames = 0; m_stale = 0;
    endtask

    // Advance one clock; inputs are stable at the edge and the model consumes them.
    task automatic step();
        bit vsf, was_waiting, was_due, was_ready;
        @(posedge iVGA_CLK);
        vsf         = m_prev_vs && !iVS;
        was_waiting = m_waiting;
        was_due     = m_commit_due;
        was_ready   = !was_waiting && !was_due;
        m_prev_vs   = iVS;
        m_swap      = 0;
        if (vsf) m_frames++;
        if (was_due) begin
            m_p1 = m_pend1; m_p2 = m_pend2; m_swap = 1; m_stale = 0; m_commit_due = 0;
        end else if (vsf && !was_waiting && m_stale < 255) begin
            m_stale++;
        end
        if (was_waiting && vsf) begin
            m_waiting = 0; m_commit_due = 1;
        end
        if (was_ready && in_valid) begin
            m_pend1 = p1_in; m_pend2 = p2_in; m_waiting = 1;
        end
        #1;
    endtask

    task automatic vsync(input int low_cycles, input int high_cycles);
        iVS = 1'b0;
        repeat (low_cycles) step();
        iVS = 1'b1;
        repeat (high_cycles) step();
    endtask

    task automatic apply_reset();
        iVS = 1'b1; in_valid = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        repeat (2) begin
            @(posedge iVGA_CLK);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        iVS = 1'b1; in_valid = 1'b0; p1_in = '0; p2_in = '0;
        reset = 1'b1;
        #3;
        model_reset();
        n_checks++; if (p1VGA !== '0 || p2VGA !== '0) begin n_fail++;
            $display("FAIL reset_vga: got %h/%h expected 0/0", p1VGA, p2VGA); end
        n_checks++; if (swap_pulse !== 1'b0) begin n_fail++;
            $display("FAIL reset_swap: got %b expected 0", swap_pulse); end
        n_checks++; if (frame_cnt !== 16'd0 || anim_phase !== 2'd0 || stale_cnt !== 8'd0) begin n_fail++;
            $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", frame_cnt, anim_phase, stale_cnt); end
        @(posedge iVGA_CLK); #1;
        reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1 || fsm_state !== 2'd0) begin n_fail++;
            $display("FAIL reset_ready: got ready=%b state=%0d expected ready=1 state=0", in_ready, fsm_state); end
    endtask

    task automatic test_basic_commit();
        logic [127:0] a, b;
        a = rand128(); b = rand128();
        p1_in = a; p2_in = b; in_valid = 1'b1;
        step();
        in_valid = 1'b0; p1_in = rand128(); p2_in = rand128();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL basic_ready_low: got %b expected 0", in_ready); end
        repeat ($urandom_range(1, 4)) step();
        iVS = 1'b0;
        step();
        n_checks++; if (p1VGA !== '0 || swap_pulse !== 1'b0) begin n_fail++;
            $display("FAIL basic_no_early: got p1=%h swap=%b expected p1=0 swap=0", p1VGA, swap_pulse); end
        step();
        n_checks++; if (p1VGA !== a || p2VGA !== b) begin n_fail++;
            $display("FAIL basic_vga: got %h/%h expected %h/%h", p1VGA, p2VGA, a, b); end
        n_checks++; if (swap_pulse !== 1'b1) begin n_fail++;
            $display("FAIL basic_swap: got %b expected 1", swap_pulse); end
        iVS = 1'b1;
        step();
        n_checks++; if (swap_pulse !== 1'b0 || in_ready !== 1'b1 || p1VGA !== a) begin n_fail++;
            $display("FAIL basic_after: got swap=%b ready=%b p1=%h expected 0/1/%h", swap_pulse, in_ready, p1VGA, a); end
    endtask

    task automatic test_backpressure();
        logic [127:0] c, d;
        c = rand128(); d = rand128();
        p1_in = c; p2_in = ~c; in_valid = 1'b1;
        step();
        p1_in = d; p2_in = ~d;
        repeat ($urandom_range(2, 6)) begin
            step();
            n_checks++; if (in_ready !== 1'b0) begin n_fail++;
                $display("FAIL bp_ready: got %b expected 0", in_ready); end
        end
        iVS = 1'b0;
        step(); step();
        n_checks++; if (p1VGA !== c || p2VGA !== ~c || swap_pulse !== 1'b1) begin n_fail++;
            $display("FAIL bp_commit: got p1=%h swap=%b expected p1=%h swap=1", p1VGA, swap_pulse, c); end
        iVS = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL bp_d_accept: got ready=%b expected 0", in_ready); end
        vsync(2, 2);
        n_checks++; if (p1VGA !== d || p2VGA !== ~d) begin n_fail++;
            $display("FAIL bp_d_commit: got %h expected %h", p1VGA, d); end
    endtask

    task automatic test_simultaneous();
        logic [127:0] e, prev;
        e = rand128(); prev = p1VGA;
        p1_in = e; p2_in = e ^ 128'h1; in_valid = 1'b1; iVS = 1'b0;
        step();
        in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL simul_accept: got ready=%b expected 0", in_ready); end
        repeat (3) begin
            step();
            n_checks++; if (swap_pulse !== 1'b0 || p1VGA !== prev) begin n_fail++;
                $display("FAIL simul_no_swap: got swap=%b p1=%h expected 0/%h", swap_pulse, p1VGA, prev); end
        end
        iVS = 1'b1; step();
        iVS = 1'b0; step(); step();
        n_checks++; if (p1VGA !== e || p2VGA !== (e ^ 128'h1) || swap_pulse !== 1'b1) begin n_fail++;
            $display("FAIL simul_commit: got p1=%h swap=%b expected %h/1", p1VGA, swap_pulse, e); end
        iVS = 1'b1; step();
    endtask

    task automatic test_counters();
        apply_reset();
        repeat (8) vsync($urandom_range(1, 3), $urandom_range(1, 3));
        n_checks++; if (anim_phase !== 2'd1) begin n_fail++;
            $display("FAIL cnt_anim8: got %0d expected 1", anim_phase); end
        repeat (25) vsync($urandom_range(1, 3), $urandom_range(1, 3));
        n_checks++; if (frame_cnt !== 16'd33 || anim_phase !== 2'd0 || stale_cnt !== 8'd33) begin n_fail++;
            $display("FAIL cnt_33: got %0d/%0d/%0d expected 33/0/33", frame_cnt, anim_phase, stale_cnt); end
        repeat (300) vsync(1, $urandom_range(1, 2));
        n_checks++; if (stale_cnt !== 8'd255) begin n_fail++;
            $display("FAIL cnt_stale_sat: got %0d expected 255", stale_cnt); end
        n_checks++; if (frame_cnt !== 16'd333 || anim_phase !== 2'd1 || w_frame_cnt !== 4'd13) begin n_fail++;
            $display("FAIL cnt_333: got %0d/%0d/%0d expected 333/1/13", frame_cnt, anim_phase, w_frame_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] f;
        f = rand128();
        p1_in = rand128(); p2_in = rand128(); in_valid = 1'b1;
        step(); in_valid = 1'b0;
        vsync(2, 2);
        p1_in = f; p2_in = f; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        iVS = 1'b0;
        step();
        reset = 1'b1;
        #2;
        model_reset();
        n_checks++; if (p1VGA !== '0 || p2VGA !== '0 || swap_pulse !== 1'b0) begin n_fail++;
            $display("FAIL mid_reset_out: got p1=%h swap=%b expected 0/0", p1VGA, swap_pulse); end
        n_checks++; if (frame_cnt !== 16'd0 || stale_cnt !== 8'd0 || anim_phase !== 2'd0) begin n_fail++;
            $display("FAIL mid_reset_cnt: got %0d/%0d/%0d expected 0/0/0", frame_cnt, stale_cnt, anim_phase); end
        iVS = 1'b1;
        @(posedge iVGA_CLK); #1;
        reset = 1'b0;
        repeat (4) begin
            step();
            n_checks++; if (swap_pulse !== 1'b0) begin n_fail++;
                $display("FAIL mid_no_swap: got %b expected 0", swap_pulse); end
        end
        vsync(2, 2);
        n_checks++; if (p1VGA !== '0 || p2VGA !== '0) begin n_fail++;
            $display("FAIL mid_vga_zero: got %h expected 0", p1VGA); end
    endtask

    task automatic test_frame_wrap();
        apply_reset();
        repeat (15) vsync($urandom_range(1, 2), $urandom_range(1, 2));
        n_checks++; if (w_frame_cnt !== 4'd15) begin n_fail++;
            $display("FAIL wrap_15: got %0d expected 15", w_frame_cnt); end
        vsync(1, 1);
        n_checks++; if (w_frame_cnt !== 4'd0 || frame_cnt !== 16'd16) begin n_fail++;
            $display("FAIL wrap_16: got %0d/%0d expected 0/16", w_frame_cnt, frame_cnt); end
    endtask

    task automatic test_random();
        int low_left;
        apply_reset();
        low_left = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            p1_in = rand128(); p2_in = rand128();
            if (low_left > 0) begin
                iVS = 1'b0; low_left--;
            end else if (iVS == 1'b1 && $urandom_range(0, 5) == 0) begin
                iVS = 1'b0; low_left = $urandom_range(0, 2);
            end else begin
                iVS = 1'b1;
            end
            step();
            n_checks++; if (p1VGA !== m_p1 || p2VGA !== m_p2) begin n_fail++;
                $display("FAIL rand_vga@%0d: got %h expected %h", cyc, p1VGA, m_p1); end
            n_checks++; if (swap_pulse !== m_swap || in_ready !== m_ready()) begin n_fail++;
                $display("FAIL rand_ctl@%0d: got swap=%b ready=%b expected %b/%b", cyc, swap_pulse, in_ready, m_swap, m_ready()); end
            n_checks++; if (frame_cnt !== 16'(m_frames) || w_frame_cnt !== 4'(m_frames % 16)
                            || anim_phase !== 2'((m_frames / ANIM_DIV) % 4) || stale_cnt !== 8'(m_stale)) begin n_fail++;
                $display("FAIL rand_cnt@%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", cyc, frame_cnt, anim_phase,
                         stale_cnt, m_frames, (m_frames / ANIM_DIV) % 4, m_stale); end
        end
        in_valid = 1'b0; iVS = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_backpressure();
        test_simultaneous();
        test_counters();
        test_reset_mid();
        test_frame_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
